// File: rtl/primo_prefetch_pkg.sv
// primo_prefetch_pkg: shared state encoding for the prime prefetcher.
package primo_prefetch_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        SKIP = 3'd2,
        WAIT = 3'd3,
        ERR  = 3'd4
    } state_t;
endpackage

// File: rtl/primo_fifo.sv
// primo_fifo: first-word-fall-through FIFO; pointers and count reset, storage not.
module primo_fifo #(
    parameter int WIDTH_LOG = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [(1<<WIDTH_LOG)-1:0]   din,
    output logic [(1<<WIDTH_LOG)-1:0]   dout,
    output logic [DEPTH_LOG:0]          count,
    output logic                        empty,
    output logic                        full
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    logic [(1<<WIDTH_LOG)-1:0] mem [DEPTH];
    logic [DEPTH_LOG-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (DEPTH_LOG+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // a simultaneous pop frees the slot, so push at full is still legal
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
        end
endmodule

// File: rtl/primo_prefetch.sv
// primo_prefetch: requests primes from primogen and buffers them on a valid/ready stream.
module primo_prefetch
    import primo_prefetch_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    output logic                        gen_go,
    input  logic                        gen_ready,
    input  logic                        gen_error,
    input  logic [(1<<WIDTH_LOG)-1:0]   gen_res,
    output logic                        out_valid,
    output logic [(1<<WIDTH_LOG)-1:0]   out_data,
    input  logic                        out_ready,
    output logic [DEPTH_LOG:0]          count,
    output logic                        busy,
    output logic                        err
);
    state_t state;
    logic push, empty, full;
    assign push      = state == WAIT && gen_ready && !gen_error;
    assign out_valid = !empty;
    primo_fifo #(.WIDTH_LOG(WIDTH_LOG), .DEPTH_LOG(DEPTH_LOG)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_ready),
        .din   (gen_res),
        .dout  (out_data),
        .count (count),
        .empty (empty),
        .full  (full)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            gen_go <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable && gen_ready && !err && !full) begin
                    state  <= REQ;
                    gen_go <= 1'b1;
                    busy   <= 1'b1;
                end
                REQ: begin
                    state  <= SKIP;
                    gen_go <= 1'b0;
                end
                // primogen's ready is still stale the cycle after it takes go
                SKIP: state <= WAIT;
                WAIT: if (gen_ready) begin
                    busy  <= 1'b0;
                    err   <= gen_error;
                    state <= gen_error ? ERR : IDLE;
                end
                ERR: state <= ERR;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_primo_prefetch.sv
// tb_primo_prefetch: directed checks of the prefetcher against a behavioural primogen stub.
module tb_primo_prefetch;
    logic clk = 0, rst_n = 0, enable = 0, out_ready = 0;
    logic gen_go, gen_ready, gen_error, out_valid, busy, err;
    logic [15:0] gen_res, out_data;
    logic [2:0] count;
    int checks = 0, errors = 0;
    int err_at = 0, lat, nreq;
    int go_cnt, mon_bad = 0, one_seen = 0;
    logic prev_go, prev_busy;

    typedef struct {int head; int cnt;} vec_t;
    vec_t v[8];

    always #5 clk = ~clk;

    primo_prefetch #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .gen_go(gen_go),
        .gen_ready(gen_ready), .gen_error(gen_error), .gen_res(gen_res),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .busy(busy), .err(err)
    );

    function automatic int nth_prime(input int n);
        int k = 0, p = 1;
        while (k < n) begin
            bit pr;
            p++;
            pr = 1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) pr = 0;
            if (pr) k++;
        end
        return p;
    endfunction

    // primogen stand-in: drops ready after go, busy for 1..3 extra cycles
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gen_ready <= 1; gen_res <= 1; gen_error <= 0; lat <= 0; nreq <= 0;
        end else if (gen_go && gen_ready) begin
            gen_ready <= 0; lat <= 1 + nreq % 3; nreq <= nreq + 1;
        end else if (!gen_ready) begin
            if (lat == 0) begin
                gen_ready <= 1;
                gen_res   <= 16'(nth_prime(nreq));
                gen_error <= nreq == err_at;
            end else lat <= lat - 1;
        end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            go_cnt <= 0; prev_go <= 0; prev_busy <= 0;
        end else begin
            prev_go <= gen_go;
            prev_busy <= busy;
            if (gen_go) go_cnt <= go_cnt + 1;
            if (gen_go && (prev_go || prev_busy)) mon_bad <= mon_bad + 1;
            if (out_valid && out_data == 1) one_seen <= one_seen + 1;
        end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int e);
        err_at = e; enable = 0; out_ready = 0; rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int n;
        v[0] = '{3, 3};  v[1] = '{5, 3};  v[2] = '{7, 3};  v[3] = '{11, 3};
        v[4] = '{13, 3}; v[5] = '{17, 3}; v[6] = '{19, 3}; v[7] = '{23, 3};

        // reset state, then fill
        do_reset(0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_go", gen_go, 0);
        enable = 1;
        for (int i = 0; i < 200 && count != 4; i++) @(negedge clk);
        chk("fill_count", count, 4);
        repeat (20) @(negedge clk);
        chk("fill_go_cnt", go_cnt, 4);
        chk("fill_head", out_data, 2);
        chk("fill_busy", busy, 0);

        // single pops from full: head advances, one refill each
        foreach (v[k]) begin
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
            chk("pop_head", out_data, v[k].head);
            chk("pop_count", count, v[k].cnt);
            for (int i = 0; i < 50 && count != 4; i++) @(negedge clk);
            chk("refill_count", count, 4);
            repeat (3) @(negedge clk);
            chk("refill_go_cnt", go_cnt, 5 + k);
        end

        // streaming
        do_reset(0);
        out_ready = 1; enable = 1;
        n = 0;
        for (int i = 0; i < 600 && n < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("stream", out_data, nth_prime(n + 1));
                n++;
            end
        end
        chk("stream_n", n, 10);

        // error on third request
        do_reset(3);
        enable = 1;
        for (int i = 0; i < 200 && !err; i++) @(negedge clk);
        chk("err_flag", err, 1);
        chk("err_count", count, 2);
        repeat (20) @(negedge clk);
        chk("err_busy", busy, 0);
        chk("err_go_cnt", go_cnt, 3);
        chk("err_head0", out_data, 2);
        out_ready = 1;
        @(negedge clk);
        chk("err_head1", out_data, 3);
        @(negedge clk);
        out_ready = 0;
        chk("err_drained", count, 0);
        chk("err_valid", out_valid, 0);
        chk("err_sticky", err, 1);

        // enable dropped while in SKIP
        do_reset(0);
        chk("rst2_err", err, 0);
        enable = 1;
        for (int i = 0; i < 50 && !gen_go; i++) @(negedge clk);
        chk("en_go", gen_go, 1);
        @(negedge clk);
        enable = 0;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk("en_count", count, 1);
        repeat (20) @(negedge clk);
        chk("en_go_cnt", go_cnt, 1);
        chk("en_busy", busy, 0);
        enable = 1;
        for (int i = 0; i < 50 && count != 2; i++) @(negedge clk);
        chk("en_resume", count, 2);
        chk("en_head", out_data, 2);

        // asynchronous reset while waiting on primogen
        do_reset(0);
        enable = 1;
        for (int i = 0; i < 50 && count == 0; i++) @(negedge clk);
        for (int i = 0; i < 50 && !gen_go; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_count", count, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_go", gen_go, 0);
        out_ready = 1;
        @(negedge clk);
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        chk("mid_first", out_valid ? int'(out_data) : -1, 2);

        chk("go_protocol", mon_bad, 0);
        chk("no_res_one", one_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
